imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Write-side counterpart of the instruction fetch path: receives a byte stream (e.g. from UART RX) and writes
//   32-bit words into instruction BRAM before the core runs.
// - Stream format: 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
// - Holds the core in reset via busy while loading; the fetch side reads mem[addr>>2], so loader addresses are byte addresses.
// PARAMETERS
// - DEPTH      32000    instruction memory depth in 32-bit words; N > DEPTH is an error
// - TIMEOUT    1000000  max clk cycles between accepted bytes once a load is active; expiry is an error
// - CNT_W      24       width of word counter / word_count output (must hold DEPTH)
// PORTS
// - clk         in   1      clock
// - rst         in   1      synchronous, active-high reset
// - start       in   1      pulse: begin (or restart) a load
// - rx_valid    in   1      byte available
// - rx_data     in   8      byte value
// - rx_ready    out  1      loader accepts byte this cycle (transfer = rx_valid & rx_ready)
// - mem_we      out  1      one-cycle write strobe to instruction BRAM
// - mem_addr    out  32     byte address, always word-aligned (word index << 2)
// - mem_wdata   out  32     assembled word
// - busy        out  1      load in progress (core held in reset)
// - done        out  1      load completed successfully (sticky until start/rst)
// - error       out  1      size or timeout error (sticky until start/rst)
// - word_count  out  CNT_W  words written in the current/last load
// BEHAVIOUR
// - Reset: state IDLE; rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, word_count=0,
//   byte index=0, timeout counter=0. Reset mid-load discards the partial word; already-written BRAM words stay.
// - FSM IDLE -> LEN -> DATA -> DONE | ERROR.
//   IDLE: rx_ready=0. start -> LEN; clear done/error/word_count/byte index.
//   LEN: rx_ready=1, busy=1. Accept 4 bytes into N (byte0 = bits 7:0). On the 4th byte: N==0 -> DONE;
//        N>DEPTH -> ERROR; else -> DATA.
//   DATA: rx_ready=1, busy=1. Bytes fill mem_wdata little-endian. The cycle after the 4th byte of a word is accepted,
//        mem_we=1 for exactly one cycle with mem_addr=word_count<<2; word_count increments in that same cycle.
//        After the Nth write -> DONE (the transition happens in the mem_we cycle).
//   DONE: busy=0, done=1, rx_ready=0. ERROR: busy=0, error=1, rx_ready=0. Extra bytes are left unconsumed.
//   start from DONE/ERROR -> LEN with the same clearing as from IDLE. start while in LEN/DATA is ignored.
// - Latency: last data byte accepted at cycle t -> mem_we at t+1 -> done=1 at t+2.
// - A byte accepted in the same cycle as a mem_we strobe belongs to the next word (no stall; rx_ready stays 1).
// - Timeout: counter clears on every accepted byte and on entry to LEN; it counts while in LEN/DATA with no
//   transfer; reaching TIMEOUT -> ERROR. The partial word is discarded and word_count keeps its value.
// - mem_addr/mem_wdata hold their values outside write strobes. word_count saturation is impossible (N<=DEPTH).
// STRUCTURE
// - Shared package: FSM state enum (IDLE, LEN, DATA, DONE, ERROR) and the IMEM_DEPTH constant, which is the
//   single source for this block and the fetch BRAM.
// - One natural sub-module: byte_to_word_packer (byte index 0..3, shift-in little-endian, word_valid pulse).
//   The FSM, counters and timeout stay in imem_loader.
// TESTING
// - Size handshake: start, then stream 02 00 00 00 | 13 00 00 00 | 93 00 10 00.
//   -> Writes (addr 0, 0x00000013) and (addr 4, 0x00100093); word_count=2; done=1; busy=0.
// - Zero length: start, then stream 00 00 00 00.
//   -> No mem_we; done=1 one cycle after the 4th byte.
// - Oversize (DEPTH=16): header 11 00 00 00 (N=17).
//   -> error=1, no writes, rx_ready=0.
// - Timeout (TIMEOUT=50): header N=3, one full word, then 2 bytes, then idle 50 cycles.
//   -> error=1, word_count=1, no second write.
// - Back-to-back and restart: rx_valid held high at the full byte rate.
//   -> No dropped bytes; mem_we pulses every 4 transfers.
//   Then start from DONE reloads from addr 0.
// - Reset mid-load: assert rst during DATA after 6 bytes.
//   -> All outputs return to reset values next cycle.
//   A subsequent start + full stream loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the fetch-side BRAM.
package imem_loader_pkg;

    // Single source of truth for the instruction memory size in 32-bit words.
    localparam int IMEM_DEPTH = 32000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Collects four bytes little-endian (first byte lands in bits 7:0) and flags
// the cycle in which the fourth byte arrives, presenting the full word then.
module imem_loader_byte_to_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] shift_q, shift_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        if (clear) begin
            byte_idx_d = 2'd0;
            shift_d    = 24'd0;
        end else if (byte_valid) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {byte_data, shift_q[23:8]};
        end
    end

    // The word is completed combinationally so the caller can register it in the same edge.
    assign word_valid = byte_valid && !clear && (byte_idx_q == 2'd3);
    assign word       = {byte_data, shift_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction BRAM,
// holding the core in reset (busy) until the load finishes or fails.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH   = IMEM_DEPTH,
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] word_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             xfer;
    logic             last_write;
    logic             pk_clear;
    logic             word_valid;
    logic [31:0]      word;

    // Handshake: a byte moves only in a cycle where rx_valid and rx_ready are both 1;
    // rx_ready never depends on rx_valid. It drops during the final write strobe so
    // bytes beyond the announced length stay with the sender.
    assign last_write = mem_we_q && ((word_count_q + CNT_W'(1)) == n_q);
    assign rx_ready   = (state_q == ST_LEN) || ((state_q == ST_DATA) && !last_write);
    assign xfer       = rx_valid && rx_ready;

    imem_loader_byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (xfer),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_count_d = word_count_q;
        to_cnt_d     = to_cnt_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pk_clear     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_LEN;
                    word_count_d = '0;
                    to_cnt_d     = '0;
                    pk_clear     = 1'b1;
                end
            end
            ST_LEN, ST_DATA: begin
                if (xfer) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end

                if (state_q == ST_LEN) begin
                    if (word_valid) begin
                        n_d = word[CNT_W-1:0];
                        if (word == 32'd0) begin
                            state_d = ST_DONE;
                        end else if (word > 32'(DEPTH)) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end else begin
                    if (word_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = 32'(word_count_q) << 2;
                        mem_wdata_d = word;
                    end
                    if (mem_we_q) begin
                        word_count_d = word_count_q + CNT_W'(1);
                    end
                    if (last_write) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            word_count_q <= '0;
            to_cnt_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_count_q <= word_count_d;
            to_cnt_q     <= to_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q == ST_LEN) || (state_q == ST_DATA);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of loads checked against a length/limit model,
// a write scoreboard, and hand sequences for latency, timeout and reset.
module tb_imem_loader;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 50;
  localparam int CNT_W   = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'd0;
  logic             rx_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;

  int n_checks = 0;
  int n_pass   = 0;
  int stalls   = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] n;
    int          gap_max;
    bit          fixed;
    bit          exp_done;
    bit          exp_err;
    logic [23:0] exp_wc;
  } vec_t;

  vec_t tbl[8];
  logic [31:0] fixed_w[2];

  imem_loader #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // scoreboard: every write strobe must match the oldest expected {addr, data}
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited = 0;
    if (gap_max > 0) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      n_checks++;
      $display("FAIL byte_accept: rx_ready stayed 0 for %0d cycles, expected 1", waited);
    end
    stalls += waited;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8], gap_max);
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done || error) && c < 300) begin
      tick();
      c++;
    end
    if (!(done || error)) begin
      n_checks++;
      $display("FAIL end_timeout: done/error never rose within %0d cycles", c);
    end
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] w;
    stalls = 0;
    pulse_start();
    check("start_busy", {63'd0, busy}, 64'd1);
    send_word(v.n, v.gap_max);
    if (v.n == 0) begin
      check("zero_len_done_latency", {63'd0, done}, 64'd1);
    end else if (v.n > DEPTH) begin
      check("oversize_err_latency", {63'd0, error}, 64'd1);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        w = v.fixed ? fixed_w[i] : $urandom;
        exp_q.push_back({32'(i * 4), w});
        send_word(w, v.gap_max);
      end
      // last byte at cycle t: strobe at t+1, done at t+2
      check("last_we_latency", {62'd0, mem_we, done}, 64'd2);
      tick();
      check("done_latency", {62'd0, mem_we, done}, 64'd1);
    end
    rx_valid = 1'b1;
    rx_data  = 8'hee;
    wait_end();
    tick();
    check("extra_byte_refused", {63'd0, rx_ready}, 64'd0);
    rx_valid = 1'b0;
    check("end_flags", {61'd0, busy, done, error}, {61'd0, 1'b0, v.exp_done, v.exp_err});
    check("end_word_count", 64'(word_count), 64'(v.exp_wc));
    check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    if (v.gap_max == 0 && v.exp_done) check("no_stall", 64'(stalls), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {rx_ready, mem_we, busy, done, error, 32'(word_count)}, 37'd0);
    check({name, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] w;
    logic [31:0] rn;

    fixed_w[0] = 32'h0000_0013;
    fixed_w[1] = 32'h0010_0093;

    tbl[0] = '{n: 2,  gap_max: 0, fixed: 1, exp_done: 1, exp_err: 0, exp_wc: 2};
    tbl[1] = '{n: 0,  gap_max: 0, fixed: 0, exp_done: 1, exp_err: 0, exp_wc: 0};
    tbl[2] = '{n: 17, gap_max: 0, fixed: 0, exp_done: 0, exp_err: 1, exp_wc: 0};
    tbl[3] = '{n: 16, gap_max: 0, fixed: 0, exp_done: 1, exp_err: 0, exp_wc: 16};
    tbl[4] = '{n: 5,  gap_max: 0, fixed: 0, exp_done: 1, exp_err: 0, exp_wc: 5};
    tbl[5] = '{n: 1,  gap_max: 3, fixed: 0, exp_done: 1, exp_err: 0, exp_wc: 1};
    for (int i = 6; i < 8; i++) begin
      rn = (i == 6) ? 32'($urandom_range(DEPTH, 1)) : ($urandom | 32'h0000_0100);
      // reference rule: a length above DEPTH fails with nothing written, else all words land
      tbl[i].n        = rn;
      tbl[i].gap_max  = 2;
      tbl[i].fixed    = 0;
      tbl[i].exp_done = (rn <= DEPTH);
      tbl[i].exp_err  = (rn > DEPTH);
      tbl[i].exp_wc   = (rn <= DEPTH) ? rn[23:0] : 24'd0;
    end

    // reset
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("idle_after_reset");

    for (int i = 0; i < 8; i++) run_load(tbl[i]);

    // timeout, with a start pulse mid-load that must be ignored
    pulse_start();
    send_word(32'd3, 0);
    w = $urandom;
    exp_q.push_back({32'd0, w});
    send_word(w, 0);
    rx_valid = 1'b0;
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("timeout_not_yet", {62'd0, busy, error}, 64'd2);
    tick();
    check("timeout_flags", {61'd0, busy, done, error}, 64'd1);
    check("timeout_word_count", 64'(word_count), 64'd1);
    check("timeout_rx_ready", {63'd0, rx_ready}, 64'd0);
    tick();
    check("timeout_writes_seen", 64'(exp_q.size()), 64'd0);

    // reset mid-load after 6 data bytes
    pulse_start();
    send_word(32'd4, 0);
    w = $urandom;
    exp_q.push_back({32'd0, w});
    send_word(w, 0);
    send_byte(8'h5a, 0);
    send_byte(8'ha5, 0);
    rx_valid = 1'b0;
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_load_reset");
    rst = 1'b0;
    check("reset_writes_seen", 64'(exp_q.size()), 64'd0);
    v = '{n: 3, gap_max: 0, fixed: 0, exp_done: 1, exp_err: 0, exp_wc: 3};
    run_load(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
